sensor_pwr_seq: RTL and testbench

- Parametrised power sequencer for the sensor supply rails (bias boost, core, bias, IO).
- Replaces the constant rail enables at top level.
- Brings rails up in ascending index order and down in descending order, with a programmable inter-step delay and per-rail output polarity.
- Sits between the SoC control register (up_req, step_delay) and the rail enable pins.

---
 rtl/sensor_pwr_seq_pkg.sv | 24 ++
 rtl/pwr_seq_timer.sv | 44 ++++
 rtl/sensor_pwr_seq.sv | 205 ++++++++++++++++++++
 tb/tb_sensor_pwr_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pwr_seq_pkg.sv
// Shared types for the sensor rail power sequencer.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
//
// The index width depends on the NUM_RAILS parameter of the top module,
// which a package cannot see, so it is provided as a helper function that
// the top evaluates into its own localparam IDX_W.
package sensor_pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_UP_WAIT   = 3'd1,
        ST_ON        = 3'd2,
        ST_DOWN_WAIT = 3'd3,
        ST_FAULT     = 3'd4
    } pwr_state_e;

    // $clog2(n), but never less than 1 so a single-rail build still has a
    // legal index vector.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable down-counter that paces the sequencer steps.
// Latency: expire is combinational from the count; count updates on aclk.
// Backpressure: none; load always wins over a same-cycle expiry.
//
// Ports: load/load_val start a new interval (0 is clamped to 1), rearm lets
// an expiring interval immediately restart with load_val, expire is high in
// the cycle whose edge takes the count from 1 to 0.
module pwr_seq_timer #(
    parameter int CNT_W = 24
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic             rearm,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_clamped;

    // rearm is a separate input instead of the FSM pulsing load on expiry:
    // expire is defined as masked by load, so driving load from expire
    // would form a combinational loop.
    always_comb begin
        load_clamped = (load_val == '0) ? CNT_W'(1) : load_val;
        expire       = (cnt_q == CNT_W'(1)) && !load;
        cnt_d        = cnt_q;
        if (load || (expire && rearm)) begin
            cnt_d = load_clamped;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sensor_pwr_seq.sv
// Sensor supply rail sequencer: rails up in ascending order, down in descending order, D=max(step_delay,1) cycles apart.
// Latency: all outputs registered; rail 0 enables on the edge that samples up_req=1, ready D cycles after the last rail.
// Backpressure: none; up_req is a level, ignored while powering down, and a power-up only starts from OFF.
//
// Ports: aclk/aresetn clock and async active-low reset; up_req rail request
// level; step_delay cycles between steps; rail_ena pin levels (rail_on XOR
// ACTIVE_LOW_MASK); rail_on logical state (thermometer code); busy while
// sequencing; ready when fully up; fault sticky pgood fault.
// Optional macro SENSOR_PWR_SEQ_PGOOD_MONITOR_EN adds pgood/fault_clr ports
// and the FAULT state; without it fault is tied 0.
module sensor_pwr_seq
    import sensor_pwr_seq_pkg::*;
#(
    parameter int                   NUM_RAILS       = 4,   // 1..16
    parameter int                   CNT_W           = 24,
    parameter logic [NUM_RAILS-1:0] ACTIVE_LOW_MASK = NUM_RAILS'(4'b1000)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 up_req,
    input  logic [CNT_W-1:0]     step_delay,
    output logic [NUM_RAILS-1:0] rail_ena,
    output logic [NUM_RAILS-1:0] rail_on,
    output logic                 busy,
    output logic                 ready,
    output logic                 fault
`ifdef SENSOR_PWR_SEQ_PGOOD_MONITOR_EN
    ,
    input  logic [NUM_RAILS-1:0] pgood,
    input  logic                 fault_clr
`endif
);

    localparam int             IDX_W    = calc_idx_w(NUM_RAILS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

    pwr_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_RAILS-1:0] rail_on_q, rail_on_d;
    logic [NUM_RAILS-1:0] rail_ena_q;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 tmr_load, tmr_rearm, tmr_expire;
    logic                 go_fault;
    logic                 rail_pg_ok;   // power-good of the rail whose delay is expiring
    logic                 on_pg_fault;  // sustained power loss while fully on

`ifdef SENSOR_PWR_SEQ_PGOOD_MONITOR_EN
    logic [NUM_RAILS-1:0] pgood_meta_q, pgood_sync_q;
    logic                 pg_low_q, pg_low_d;
    logic                 fault_q, fault_d;

    assign rail_pg_ok  = pgood_sync_q[idx_q];
    // pg_low_q remembers a low pgood seen in the previous ON cycle, so a
    // second consecutive low cycle trips the fault.
    assign pg_low_d    = (state_q == ST_ON) && !(&pgood_sync_q);
    assign on_pg_fault = (state_q == ST_ON) && pg_low_q && !(&pgood_sync_q);

    always_comb begin
        fault_d = fault_q;
        if (go_fault) begin
            fault_d = 1'b1;
        end else if ((state_q == ST_FAULT) && fault_clr && !up_req) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pgood_meta_q <= '0;
            pgood_sync_q <= '0;
            pg_low_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            pgood_meta_q <= pgood;
            pgood_sync_q <= pgood_meta_q;
            pg_low_q     <= pg_low_d;
            fault_q      <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign rail_pg_ok  = 1'b1;
    assign on_pg_fault = 1'b0;
    assign fault       = 1'b0;
`endif

    pwr_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (tmr_load),
        .rearm    (tmr_rearm),
        .load_val (step_delay),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rail_on_d = rail_on_q;
        ready_d   = ready_q;
        tmr_load  = 1'b0;
        tmr_rearm = 1'b0;
        go_fault  = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (up_req) begin
                    rail_on_d[0] = 1'b1;
                    idx_d        = '0;
                    tmr_load     = 1'b1;
                    state_d      = ST_UP_WAIT;
                end
            end
            ST_UP_WAIT: begin
                tmr_rearm = (idx_q != LAST_IDX);
                // Abort is checked first so a same-edge expiry never enables
                // another rail.
                if (!up_req) begin
                    rail_on_d[idx_q] = 1'b0;
                    tmr_load         = 1'b1;
                    state_d          = ST_DOWN_WAIT;
                end else if (tmr_expire) begin
                    if (!rail_pg_ok) begin
                        go_fault = 1'b1;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d            = idx_q + IDX_W'(1);
                        rail_on_d[idx_d] = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                        state_d = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (on_pg_fault) begin
                    go_fault = 1'b1;
                end else if (!up_req) begin
                    ready_d             = 1'b0;
                    rail_on_d[LAST_IDX] = 1'b0;
                    idx_d               = LAST_IDX;
                    tmr_load            = 1'b1;
                    state_d             = ST_DOWN_WAIT;
                end
            end
            ST_DOWN_WAIT: begin
                tmr_rearm = (idx_q != '0);
                if (tmr_expire) begin
                    if (idx_q != '0) begin
                        idx_d            = idx_q - IDX_W'(1);
                        rail_on_d[idx_d] = 1'b0;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
            end
`ifdef SENSOR_PWR_SEQ_PGOOD_MONITOR_EN
            ST_FAULT: begin
                if (fault_clr && !up_req) begin
                    state_d = ST_OFF;
                end
            end
`endif
            default: begin
                state_d   = ST_OFF;
                rail_on_d = '0;
                ready_d   = 1'b0;
            end
        endcase

        // All rails drop together on a fault rather than sequencing down.
        if (go_fault) begin
            state_d   = ST_FAULT;
            rail_on_d = '0;
            ready_d   = 1'b0;
        end

        busy_d = (state_d == ST_UP_WAIT) || (state_d == ST_DOWN_WAIT);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_OFF;
            idx_q      <= '0;
            rail_on_q  <= '0;
            rail_ena_q <= ACTIVE_LOW_MASK;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rail_on_q  <= rail_on_d;
            rail_ena_q <= rail_on_d ^ ACTIVE_LOW_MASK;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign rail_on  = rail_on_q;
    assign rail_ena = rail_ena_q;
    assign busy     = busy_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Testbench for sensor_pwr_seq (NUM_RAILS=4, ACTIVE_LOW_MASK=4'b1000).
// Stimulus pushes expected output-change events {cycle, outputs}; a monitor
// pops one event each time any output changes and compares cycle and value.
module tb_sensor_pwr_seq;

    localparam int N  = 4;
    localparam int CW = 24;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic          up_req;
    logic [CW-1:0] step_delay;
    logic [N-1:0]  rail_ena, rail_on;
    logic          busy, ready, fault;
`ifdef SENSOR_PWR_SEQ_PGOOD_MONITOR_EN
    logic [N-1:0]  pgood;
    logic          fault_clr;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] on;
        logic [3:0] ena;
        logic       busy;
        logic       ready;
        logic       fault;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;

    sensor_pwr_seq #(.NUM_RAILS(N), .CNT_W(CW), .ACTIVE_LOW_MASK(4'b1000)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .up_req     (up_req),
        .step_delay (step_delay),
        .rail_ena   (rail_ena),
        .rail_on    (rail_on),
        .busy       (busy),
        .ready      (ready),
        .fault      (fault)
`ifdef SENSOR_PWR_SEQ_PGOOD_MONITOR_EN
        ,
        .pgood      (pgood),
        .fault_clr  (fault_clr)
`endif
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ena is the active-low-mask image of on: bit 3 inverted.
    task automatic push(input int c, input logic [3:0] on, input logic b,
                        input logic r, input logic f);
        ev_t e;
        e.cyc   = c;
        e.on    = on;
        e.ena   = on ^ 4'b1000;
        e.busy  = b;
        e.ready = r;
        e.fault = f;
        exp_q.push_back(e);
    endtask

    task automatic expect_up(input int t, input int d);
        push(t,         4'b0001, 1'b1, 1'b0, 1'b0);
        push(t + d,     4'b0011, 1'b1, 1'b0, 1'b0);
        push(t + 2 * d, 4'b0111, 1'b1, 1'b0, 1'b0);
        push(t + 3 * d, 4'b1111, 1'b1, 1'b0, 1'b0);
        push(t + 4 * d, 4'b1111, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic expect_down(input int t, input int d);
        push(t,         4'b0111, 1'b1, 1'b0, 1'b0);
        push(t + d,     4'b0011, 1'b1, 1'b0, 1'b0);
        push(t + 2 * d, 4'b0001, 1'b1, 1'b0, 1'b0);
        push(t + 3 * d, 4'b0000, 1'b1, 1'b0, 1'b0);
        push(t + 4 * d, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d events pending after %0d cycles, expected 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (3) @(negedge aclk);
    endtask

    // Monitor: outputs only change on posedge or async reset, so sampling on
    // negedge sees settled values.
    logic [10:0] prev_v = {4'b0000, 4'b1000, 3'b000};

    always @(negedge aclk) begin : mon
        logic [10:0] cur;
        ev_t         e;
        cur = {rail_on, rail_ena, busy, ready, fault};
        if (cur !== prev_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_change: cycle %0d outputs 0x%0h, expected 0x%0h (no event queued)",
                         cyc, cur, prev_v);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", 32'(cyc), 32'(e.cyc));
                chk("event_outputs", 32'(cur),
                    32'({e.on, e.ena, e.busy, e.ready, e.fault}));
            end
        end
        if (aresetn) begin
            assert ((rail_on & (rail_on + 4'd1)) == 4'd0)
            else begin
                failures++;
                $display("FAIL thermometer: rail_on=%b, expected contiguous ones from bit 0", rail_on);
            end
        end
        prev_v = cur;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        up_req     = 1'b1;
        step_delay = 24'd10;
`ifdef SENSOR_PWR_SEQ_PGOOD_MONITOR_EN
        pgood      = 4'b1111;
        fault_clr  = 1'b0;
`endif
        // Reset with up_req held high.
        repeat (3) @(negedge aclk);
        chk("reset_rail_ena", 32'(rail_ena), 32'h8);
        chk("reset_rail_on",  32'(rail_on),  32'h0);
        chk("reset_busy",     32'(busy),     32'h0);
        chk("reset_ready",    32'(ready),    32'h0);
        chk("reset_fault",    32'(fault),    32'h0);
        aresetn = 1'b1;
        t = cyc + 1;
        expect_up(t, 10);
        drain(80);
        chk("on_rail_ena", 32'(rail_ena), 32'h7);

        // Power down from ON.
        up_req = 1'b0;
        t = cyc + 1;
        expect_down(t, 10);
        drain(80);

        // Power up from OFF, then down again.
        up_req = 1'b1;
        t = cyc + 1;
        expect_up(t, 10);
        drain(80);
        up_req = 1'b0;
        t = cyc + 1;
        expect_down(t, 10);
        drain(80);

        // Abort 4 cycles after rail 1; re-request during DOWN_WAIT is ignored
        // until OFF, then a fresh power-up starts one edge later.
        up_req = 1'b1;
        t = cyc + 1;
        push(t,      4'b0001, 1'b1, 1'b0, 1'b0);
        push(t + 10, 4'b0011, 1'b1, 1'b0, 1'b0);
        push(t + 14, 4'b0001, 1'b1, 1'b0, 1'b0);
        push(t + 24, 4'b0000, 1'b1, 1'b0, 1'b0);
        push(t + 34, 4'b0000, 1'b0, 1'b0, 1'b0);
        expect_up(t + 35, 10);
        while (cyc != t + 13) @(negedge aclk);
        up_req = 1'b0;
        while (cyc != t + 17) @(negedge aclk);
        up_req = 1'b1;
        drain(120);
        up_req = 1'b0;
        t = cyc + 1;
        expect_down(t, 10);
        drain(80);

        // Abort on the same edge as the first expiry: abort wins.
        up_req = 1'b1;
        t = cyc + 1;
        push(t,      4'b0001, 1'b1, 1'b0, 1'b0);
        push(t + 10, 4'b0000, 1'b1, 1'b0, 1'b0);
        push(t + 20, 4'b0000, 1'b0, 1'b0, 1'b0);
        while (cyc != t + 9) @(negedge aclk);
        up_req = 1'b0;
        drain(60);

        // step_delay=0 behaves as 1-cycle spacing.
        step_delay = 24'd0;
        up_req = 1'b1;
        t = cyc + 1;
        expect_up(t, 1);
        drain(30);
        up_req = 1'b0;
        t = cyc + 1;
        expect_down(t, 1);
        drain(30);

        // Reset mid-sequence drops all rails without a clock edge.
        step_delay = 24'd10;
        up_req = 1'b1;
        t = cyc + 1;
        push(t,      4'b0001, 1'b1, 1'b0, 1'b0);
        push(t + 10, 4'b0011, 1'b1, 1'b0, 1'b0);
        while (cyc != t + 15) @(negedge aclk);
        #2;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        aresetn = 1'b0;
        up_req  = 1'b0;
        #1;
        chk("async_rst_rail_ena", 32'(rail_ena), 32'h8);
        chk("async_rst_rail_on",  32'(rail_on),  32'h0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        drain(10);

`ifdef SENSOR_PWR_SEQ_PGOOD_MONITOR_EN
        // pgood[2] stuck low: fault at rail 2's expiry, held while up_req=1.
        pgood  = 4'b1011;
        up_req = 1'b1;
        t = cyc + 1;
        push(t,      4'b0001, 1'b1, 1'b0, 1'b0);
        push(t + 10, 4'b0011, 1'b1, 1'b0, 1'b0);
        push(t + 20, 4'b0111, 1'b1, 1'b0, 1'b0);
        push(t + 30, 4'b0000, 1'b0, 1'b0, 1'b1);
        drain(60);
        fault_clr = 1'b1;
        repeat (5) @(negedge aclk);
        chk("fault_held_with_up_req", 32'(fault), 32'h1);
        up_req = 1'b0;
        t = cyc + 1;
        push(t, 4'b0000, 1'b0, 1'b0, 1'b0);
        drain(10);
        fault_clr = 1'b0;
        pgood     = 4'b1111;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
